// File: rtl/overlap_sched_pkg.sv
// Shared types for the overlap-add frame scheduler: window sequences, FSM states,
// default frame geometry and the window-sequence transition rule.
package overlap_pkg;

    typedef enum logic [1:0] {
        ONLY_LONG   = 2'd0,
        LONG_START  = 2'd1,
        EIGHT_SHORT = 2'd2,
        LONG_STOP   = 2'd3
    } win_seq_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    localparam int FRAME_LEN_DEF = 1024;
    localparam int SHORT_LEN_DEF = 128;

    // A long-ending window may not jump straight into short/stop, and a
    // short-ending window may not jump straight back to long/start.
    function automatic logic seq_legal(input win_seq_e prev, input win_seq_e cur);
        case (prev)
            ONLY_LONG, LONG_STOP: return !(cur == EIGHT_SHORT || cur == LONG_STOP);
            default:              return !(cur == ONLY_LONG || cur == LONG_START);
        endcase
    endfunction

endpackage

// File: rtl/overlap_sched_ctr.sv
// Per-frame sample counter: clears on descriptor accept, advances per command
// handshake, and flags the final sample so the FSM can end the frame.
module overlap_sched_ctr #(
    parameter int  FRAME_LEN = 1024,
    localparam int IDX_W     = $clog2(FRAME_LEN)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             inc,
    output logic [IDX_W-1:0] idx,
    output logic             last
);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            idx <= '0;
        end else if (clr) begin
            idx <= '0;
        end else if (inc) begin
            idx <= idx + 1'b1;
        end
    end

    assign last = (idx == IDX_W'(FRAME_LEN - 1));

endmodule

// File: rtl/overlap_sched.sv
// Frame-level scheduler for the overlap-add datapath: turns one descriptor into
// FRAME_LEN per-sample commands and tracks per-channel history/window state.
module overlap_sched
    import overlap_pkg::*;
#(
    parameter int  FRAME_LEN = FRAME_LEN_DEF,
    parameter int  SHORT_LEN = SHORT_LEN_DEF,
    parameter int  NUM_CH    = 2,
    localparam int CH_W      = (NUM_CH > 1) ? $clog2(NUM_CH) : 1,
    localparam int IDX_W     = $clog2(FRAME_LEN),
    localparam int ADDR_W    = $clog2(NUM_CH * FRAME_LEN)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              in_desc_valid,
    output logic              in_desc_ready,
    input  logic [1:0]        in_desc_seq,
    input  logic [CH_W-1:0]   in_desc_ch,
    input  logic              flush_ch_valid,
    input  logic [CH_W-1:0]   flush_ch,
    output logic              cmd_valid,
    input  logic              cmd_ready,
    output logic [IDX_W-1:0]  cmd_idx,
    output logic [CH_W-1:0]   cmd_ch,
    output logic [1:0]        cmd_seq,
    output logic [2:0]        cmd_blk,
    output logic [ADDR_W-1:0] cmd_hist_addr,
    output logic              cmd_zero_hist,
    output logic              frame_done,
    output logic              err_seq,
    output logic [1:0]        dbg_state
);

    localparam int BLK_SH = $clog2(SHORT_LEN);

    // Handshakes: a transfer happens on a rising edge where valid && ready; once
    // valid is raised the payload holds until that edge and valid never drops early.

    state_e            state;
    win_seq_e          cur_seq;
    logic [CH_W-1:0]   cur_ch;
    logic              zero_hist;
    logic [NUM_CH-1:0] primed;
    win_seq_e          prev_seq [NUM_CH];

    logic             accept;
    logic             fire;
    logic             last;
    logic [IDX_W-1:0] idx;

    assign accept = (state == ST_IDLE) && in_desc_ready && in_desc_valid;
    assign fire   = (state == ST_RUN) && cmd_valid && cmd_ready;

    overlap_sched_ctr #(.FRAME_LEN(FRAME_LEN)) u_ctr (
        .clk  (clk),
        .rst  (reset),
        .clr  (accept),
        .inc  (fire && !last),
        .idx  (idx),
        .last (last)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state         <= ST_IDLE;
            in_desc_ready <= 1'b0;
            cmd_valid     <= 1'b0;
            frame_done    <= 1'b0;
            err_seq       <= 1'b0;
            cur_seq       <= ONLY_LONG;
            cur_ch        <= '0;
            zero_hist     <= 1'b0;
            primed        <= '0;
            for (int i = 0; i < NUM_CH; i++) prev_seq[i] <= ONLY_LONG;
        end else begin
            frame_done <= 1'b0;
            err_seq    <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (accept) begin
                        in_desc_ready <= 1'b0;
                        cur_seq       <= win_seq_e'(in_desc_seq);
                        cur_ch        <= in_desc_ch;
                        zero_hist     <= !primed[in_desc_ch];
                        err_seq       <= primed[in_desc_ch] &&
                                         !seq_legal(prev_seq[in_desc_ch], win_seq_e'(in_desc_seq));
                        cmd_valid     <= 1'b1;
                        state         <= ST_RUN;
                    end else begin
                        in_desc_ready <= 1'b1;
                    end
                end
                ST_RUN: begin
                    if (fire && last) begin
                        cmd_valid  <= 1'b0;
                        frame_done <= 1'b1;
                        state      <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    primed[cur_ch]   <= 1'b1;
                    prev_seq[cur_ch] <= cur_seq;
                    in_desc_ready    <= 1'b1;
                    state            <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
            // Placed last so a flush overrides the DONE update for the same channel.
            if (flush_ch_valid) begin
                primed[flush_ch]   <= 1'b0;
                prev_seq[flush_ch] <= ONLY_LONG;
            end
        end
    end

    assign cmd_idx       = idx;
    assign cmd_ch        = cur_ch;
    assign cmd_seq       = cur_seq;
    assign cmd_blk       = (cur_seq == EIGHT_SHORT) ? 3'(idx >> BLK_SH) : 3'd0;
    assign cmd_hist_addr = ADDR_W'({cur_ch, idx});
    assign cmd_zero_hist = zero_hist;
    assign dbg_state     = state;

endmodule

// File: tb/tb_overlap_sched.sv
// Directed bench for overlap_sched: frames with hand-derived expectations for
// history zeroing, window-sequence errors, flush, stalls and mid-frame reset.
module tb_overlap_sched;
  import overlap_pkg::*;

  localparam int FL = 1024;
  localparam int SL = 128;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  logic       in_desc_valid, in_desc_ready;
  logic [1:0] in_desc_seq;
  logic       in_desc_ch;
  logic       flush_ch_valid, flush_ch;
  logic       cmd_valid, cmd_ready;
  logic [9:0] cmd_idx;
  logic       cmd_ch;
  logic [1:0] cmd_seq;
  logic [2:0] cmd_blk;
  logic [10:0] cmd_hist_addr;
  logic       cmd_zero_hist, frame_done, err_seq;
  logic [1:0] dbg_state;

  overlap_sched dut (
    .clk(clk), .reset(reset),
    .in_desc_valid(in_desc_valid), .in_desc_ready(in_desc_ready),
    .in_desc_seq(in_desc_seq), .in_desc_ch(in_desc_ch),
    .flush_ch_valid(flush_ch_valid), .flush_ch(flush_ch),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_idx(cmd_idx), .cmd_ch(cmd_ch), .cmd_seq(cmd_seq), .cmd_blk(cmd_blk),
    .cmd_hist_addr(cmd_hist_addr), .cmd_zero_hist(cmd_zero_hist),
    .frame_done(frame_done), .err_seq(err_seq), .dbg_state(dbg_state)
  );

  // ---------------- scoreboard ----------------
  int n_cmp = 0;
  int n_bad = 0;
  logic [9:0] exp_q[$];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  // ---------------- driver ----------------
  // exp_done_cyc: cycle (accept cycle = 1) where frame_done is expected, 0 = unchecked.
  // abort_at: sample index at which reset is pulsed mid-frame, -1 = none.
  task automatic run_frame(input int ch, input int seq, input bit exp_zero, input bit exp_err,
                           input int rdy_pct, input bit flush_at_done, input int abort_at,
                           input int exp_done_cyc);
    int  cyc, guard;
    bit  done;
    logic [9:0] e;
    exp_q.delete();
    for (int i = 0; i < FL; i++) exp_q.push_back(10'(i));
    @(negedge clk);
    in_desc_valid = 1'b1;
    in_desc_seq   = 2'(seq);
    in_desc_ch    = 1'(ch);
    guard = 0;
    while (!in_desc_ready && guard < 50) begin
      @(negedge clk);
      guard++;
    end
    check("desc_ready", in_desc_ready, 1);
    cyc = 1;
    @(negedge clk);
    cyc++;
    in_desc_valid = 1'b0;
    check("err_seq_at_accept", err_seq, exp_err);
    check("desc_ready_busy", in_desc_ready, 0);
    done = 1'b0;
    while (!done && cyc < 20000) begin
      if (exp_q.size() > 0) begin
        e = exp_q[0];
        check("cmd_valid", cmd_valid, 1);
        check("frame_done_early", frame_done, 0);
        check("cmd_idx", cmd_idx, e);
        check("cmd_ch", cmd_ch, ch);
        check("cmd_seq", cmd_seq, seq);
        check("cmd_blk", cmd_blk, (seq == 2) ? e / SL : 0);
        check("cmd_hist_addr", cmd_hist_addr, ch * FL + e);
        check("cmd_zero_hist", cmd_zero_hist, exp_zero);
        if (cyc > 2) check("err_seq_idle", err_seq, 0);
        if (abort_at >= 0 && int'(e) == abort_at) begin
          cmd_ready = 1'b0;
          reset = 1'b1;
          #1;
          check("abort_cmd_valid", cmd_valid, 0);
          check("abort_frame_done", frame_done, 0);
          check("abort_idx", cmd_idx, 0);
          repeat (3) @(negedge clk);
          reset = 1'b0;
          repeat (4) begin
            @(negedge clk);
            check("post_abort_done", frame_done, 0);
            check("post_abort_valid", cmd_valid, 0);
          end
          return;
        end
        cmd_ready = ($urandom_range(0, 99) < rdy_pct);
        if (cmd_ready) void'(exp_q.pop_front());
      end else begin
        check("frame_done", frame_done, 1);
        check("cmd_valid_after_last", cmd_valid, 0);
        if (exp_done_cyc != 0) check("frame_done_cycle", cyc, exp_done_cyc);
        if (flush_at_done) begin
          flush_ch_valid = 1'b1;
          flush_ch       = 1'(ch);
        end
        cmd_ready = 1'b0;
        done = 1'b1;
      end
      @(negedge clk);
      cyc++;
    end
    if (!done) check("frame_timeout", 0, 1);
    flush_ch_valid = 1'b0;
    check("frame_done_pulse", frame_done, 0);
    check("idle_ready", in_desc_ready, 1);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    reset = 1'b1;
    in_desc_valid = 1'b0; in_desc_seq = 2'd0; in_desc_ch = 1'b0;
    flush_ch_valid = 1'b0; flush_ch = 1'b0;
    cmd_ready = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_desc_ready", in_desc_ready, 0);
    check("rst_cmd_valid", cmd_valid, 0);
    check("rst_frame_done", frame_done, 0);
    check("rst_err_seq", err_seq, 0);
    check("rst_cmd_idx", cmd_idx, 0);
    check("rst_cmd_ch", cmd_ch, 0);
    check("rst_cmd_seq", cmd_seq, 0);
    check("rst_cmd_blk", cmd_blk, 0);
    check("rst_hist_addr", cmd_hist_addr, 0);
    check("rst_zero_hist", cmd_zero_hist, 0);
    reset = 1'b0;
    @(negedge clk);
    check("ready_after_rst", in_desc_ready, 1);

    // 1: first frame on an unprimed channel, full-rate sink
    run_frame(0, ONLY_LONG,   1, 0, 100, 0, -1, 1026);
    // 2: ch0 now primed; ch1 short frame still unprimed
    run_frame(0, ONLY_LONG,   0, 0, 100, 0, -1, 1026);
    run_frame(1, EIGHT_SHORT, 1, 0, 100, 0, -1, 1026);
    // 3: illegal long->short on primed ch0, then legal short->stop
    run_frame(0, EIGHT_SHORT, 0, 1, 100, 0, -1, 0);
    run_frame(0, LONG_STOP,   0, 0, 100, 0, -1, 0);
    // 4: sink ready ~30% of cycles
    run_frame(1, LONG_STOP,   0, 0, 30, 0, -1, 0);
    run_frame(0, ONLY_LONG,   0, 0, 30, 0, -1, 0);
    // 5: flush coinciding with frame_done wins; following short frame unprimed, no error
    run_frame(0, ONLY_LONG,   0, 0, 100, 1, -1, 0);
    run_frame(0, EIGHT_SHORT, 1, 0, 100, 0, -1, 0);
    // 6: reset mid-frame, then restart unprimed; then an illegal start->long
    run_frame(1, ONLY_LONG,   0, 0, 100, 0, 500, 0);
    run_frame(1, LONG_START,  1, 0, 100, 0, -1, 1026);
    run_frame(1, ONLY_LONG,   0, 1, 100, 0, -1, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
